// File: rtl/snr_pkg.sv
// SNR select codes, noise-path modes and the code -> shift/mode decoder
// shared by the noise injection pipeline.
package snr_pkg;

    localparam int SNR_CODE_W = 3;
    localparam int SHIFT_W    = 4;

    localparam logic [SNR_CODE_W-1:0] SNR_MUTE   = 3'b000;
    localparam logic [SNR_CODE_W-1:0] SNR_40DB   = 3'b001;
    localparam logic [SNR_CODE_W-1:0] SNR_BYPASS = 3'b010;
    localparam logic [SNR_CODE_W-1:0] SNR_30DB   = 3'b011;
    localparam logic [SNR_CODE_W-1:0] SNR_0DB    = 3'b100;
    localparam logic [SNR_CODE_W-1:0] SNR_M10DB  = 3'b101;
    localparam logic [SNR_CODE_W-1:0] SNR_10DB   = 3'b110;
    localparam logic [SNR_CODE_W-1:0] SNR_20DB   = 3'b111;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        MUTE   = 2'd1,
        ADD    = 2'd2
    } snr_mode_t;

    typedef struct packed {
        snr_mode_t          mode;
        logic [SHIFT_W-1:0] shift;
    } snr_cfg_t;

    // Decode an SNR code into the noise arithmetic-shift amount and path mode.
    function automatic snr_cfg_t snr_shift(input logic [SNR_CODE_W-1:0] code);
        snr_cfg_t cfg;
        cfg.mode  = ADD;
        cfg.shift = '0;
        case (code)
            SNR_BYPASS: cfg.mode  = BYPASS;
            SNR_MUTE:   cfg.mode  = MUTE;
            SNR_40DB:   cfg.shift = 4'd10;
            SNR_30DB:   cfg.shift = 4'd8;
            SNR_20DB:   cfg.shift = 4'd6;
            SNR_10DB:   cfg.shift = 4'd4;
            SNR_0DB:    cfg.shift = 4'd2;
            default:    cfg.shift = 4'd0;   // SNR_M10DB: noise at full scale
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder: the sum is formed one bit wider so
// overflow shows up as a disagreement between the two top bits.
module sat_add #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              sat
);

    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] wide;

    // Sign-extend, add, and clamp toward the sign of the true result on overflow.
    always_comb begin
        wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        sum  = wide[DATA_W-1:0];
        sat  = 1'b0;
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sat = 1'b1;
            sum = wide[DATA_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/noise_inject_pipe.sv
// Two-stage valid/ready pipeline adding scaled noise to N_CH audio channels.
// Stage 1 holds samples, pre-shifted noise and the mode captured at accept;
// stage 2 holds the saturated result. Also counts saturated channel-samples.
module noise_inject_pipe
    import snr_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int N_CH         = 2,
    parameter int SHARED_NOISE = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             snr_code,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*DATA_W-1:0] noise_data,
    input  logic                   noise_valid,
    output logic                   noise_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH-1:0]        out_sat,
    output logic [CNT_W-1:0]       sat_count,
    input  logic                   clr_stats
);

    localparam int W     = N_CH * DATA_W;
    localparam int POP_W = $clog2(N_CH + 1);

    snr_cfg_t         cfg;
    logic             accept;
    logic             s1_advance;
    logic [W-1:0]     noise_shifted;
    logic [W-1:0]     sum_data;
    logic [N_CH-1:0]  add_sat;
    logic [W-1:0]     s2_data;
    logic [N_CH-1:0]  s2_sat;
    logic [POP_W-1:0] sat_pop;
    logic [CNT_W:0]   cnt_sum;
    logic             unused_noise;

    logic             s1_valid_reg;
    logic [W-1:0]     s1_data_reg;
    logic [W-1:0]     s1_noise_reg;
    snr_mode_t        s1_mode_reg;

    // With shared noise the upper lanes are ignored by design.
    assign unused_noise = ^noise_data;

    assign cfg        = snr_shift(snr_code);
    assign s1_advance = s1_valid_reg & (~out_valid | out_ready);
    assign in_ready   = rst_n & (~s1_valid_reg | s1_advance);
    assign accept     = in_valid & noise_valid & in_ready;
    assign noise_ready = accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam int LANE = (SHARED_NOISE != 0) ? 0 : gi;

            assign noise_shifted[gi*DATA_W +: DATA_W] =
                $signed(noise_data[LANE*DATA_W +: DATA_W]) >>> cfg.shift;

            sat_add #(.DATA_W(DATA_W)) u_sat_add (
                .a   (s1_data_reg[gi*DATA_W +: DATA_W]),
                .b   (s1_noise_reg[gi*DATA_W +: DATA_W]),
                .sum (sum_data[gi*DATA_W +: DATA_W]),
                .sat (add_sat[gi])
            );
        end
    endgenerate

    // Stage 1: capture samples, scaled noise and mode on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_noise_reg <= '0;
            s1_mode_reg  <= MUTE;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_data_reg  <= in_data;
            s1_noise_reg <= noise_shifted;
            s1_mode_reg  <= cfg.mode;
        end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Select the stage-2 result per channel; only the add path can saturate.
    always_comb begin
        s2_data = '0;
        s2_sat  = '0;
        for (int c = 0; c < N_CH; c++) begin
            case (s1_mode_reg)
                ADD: begin
                    s2_data[c*DATA_W +: DATA_W] = sum_data[c*DATA_W +: DATA_W];
                    s2_sat[c]                   = add_sat[c];
                end
                BYPASS:  s2_data[c*DATA_W +: DATA_W] = s1_data_reg[c*DATA_W +: DATA_W];
                default: s2_data[c*DATA_W +: DATA_W] = '0;
            endcase
        end
    end

    // Stage 2: output register, held stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            out_data  <= s2_data;
            out_sat   <= s2_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Popcount of the presented saturation flags and the widened counter sum.
    always_comb begin
        sat_pop = '0;
        for (int c = 0; c < N_CH; c++) begin
            sat_pop = sat_pop + POP_W'(out_sat[c]);
        end
        cnt_sum = {1'b0, sat_count} + (CNT_W+1)'(sat_pop);
    end

    // Saturation counter: clear wins, otherwise add on handshake without wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_stats) begin
            sat_count <= '0;
        end else if (out_valid && out_ready) begin
            sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_noise_inject_pipe.sv
// Directed scoreboard bench for noise_inject_pipe (DATA_W=32, N_CH=2, shared noise).
module tb_noise_inject_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  snr_code;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] noise_data;
    logic        noise_valid;
    logic        noise_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sat;
    logic [15:0] sat_count;
    logic        clr_stats;

    noise_inject_pipe #(
        .DATA_W(32), .N_CH(2), .SHARED_NOISE(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .snr_code(snr_code),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .noise_data(noise_data), .noise_valid(noise_valid), .noise_ready(noise_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .sat_count(sat_count), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [1:0]  sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   quiet = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got L=0x%08h R=0x%08h, required no frame",
                         out_data[31:0], out_data[63:32]);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_frame", out_data, {mon_e.r, mon_e.l});
                check("out_sat", {62'd0, out_sat}, {62'd0, mon_e.sat});
                if (!quiet)
                    $display("out %0d: L=0x%08h R=0x%08h sat=%b count=%0d",
                             n_out, out_data[31:0], out_data[63:32], out_sat, sat_count);
            end
        end
    end

    // Present one frame (called just after a rising edge) until it is accepted.
    task automatic send(input logic [2:0] code, input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] n, input logic [31:0] el, input logic [31:0] er,
                        input logic [1:0] es);
        exp_t e;
        int   waited;
        bit   done;
        waited = 0;
        done   = 1'b0;
        snr_code    = code;
        in_data     = {r, l};
        noise_data  = {32'h12345678, n};
        in_valid    = 1'b1;
        noise_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                check("noise_ready_on_accept", {63'd0, noise_ready}, 64'd1);
                e.l = el; e.r = er; e.sat = es;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            waited++;
            if (!done && waited > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
                done = 1'b1;
            end
        end
    endtask

    // Drop all inputs; the snr code is moved away to catch late sampling.
    task automatic idle();
        in_valid    = 1'b0;
        noise_valid = 1'b0;
        snr_code    = 3'b000;
    endtask

    // Wait (bounded) until every expected frame has been delivered.
    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          acc;
        int          t;
        logic [63:0] held;

        rst_n = 1'b0; snr_code = 3'b010; in_data = 64'h1111_2222_3333_4444;
        noise_data = '0; in_valid = 1'b1; noise_valid = 1'b1;
        out_ready = 1'b1; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_noise_ready", {63'd0, noise_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_sat", {62'd0, out_sat}, 64'd0);
        check("rst_sat_count", {48'd0, sat_count}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Bypass with latency check
        send(3'b010, 32'h00001000, 32'hFFFFF000, 32'h7FFFFFFF, 32'h00001000, 32'hFFFFF000, 2'b00);
        idle();
        @(negedge clk);
        check("latency_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("latency_cycle2_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        drain();

        // Arithmetic shift, positive and negative noise
        send(3'b001, 32'h0, 32'h0, 32'h40000000, 32'h00100000, 32'h00100000, 2'b00);
        send(3'b001, 32'h0, 32'h0, 32'h80000000, 32'hFFE00000, 32'hFFE00000, 2'b00);
        send(3'b111, 32'h1, 32'hFFFFFFFF, 32'h40000000, 32'h01000001, 32'h00FFFFFF, 2'b00);
        send(3'b110, 32'h1, 32'hFFFFFFFF, 32'h40000000, 32'h04000001, 32'h03FFFFFF, 2'b00);
        send(3'b100, 32'h1, 32'hFFFFFFFF, 32'h40000000, 32'h10000001, 32'h0FFFFFFF, 2'b00);
        idle();
        drain();

        // Saturation in both directions
        send(3'b101, 32'h7FFFFFF0, 32'h80000010, 32'h00000100, 32'h7FFFFFFF, 32'h80000110, 2'b01);
        idle();
        drain();
        check("sat_count_after_pos", {48'd0, sat_count}, 64'd1);
        send(3'b101, 32'h7FFFFFF0, 32'h80000010, 32'hFFFFFF00, 32'h7FFFFEF0, 32'h80000000, 2'b10);
        idle();
        drain();
        check("sat_count_after_neg", {48'd0, sat_count}, 64'd2);

        // Mute never saturates
        send(3'b000, 32'h7FFFFFF0, 32'h00005678, 32'h00000100, 32'h0, 32'h0, 2'b00);
        idle();
        drain();
        check("sat_count_after_mute", {48'd0, sat_count}, 64'd2);

        // Code changes on the cycle after accept; idle() then changes it again
        send(3'b001, 32'h0, 32'h0, 32'h40000000, 32'h00100000, 32'h00100000, 2'b00);
        send(3'b011, 32'h0, 32'h0, 32'h40000000, 32'h00400000, 32'h00400000, 2'b00);
        idle();
        drain();

        // Noise starvation: frame waiting but no noise, then noise but no frame
        in_valid = 1'b1; noise_valid = 1'b0; in_data = 64'h0000_0200_0000_0100; snr_code = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("starve_noise_ready", {63'd0, noise_ready}, 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; noise_valid = 1'b1;
        @(negedge clk);
        check("no_frame_noise_ready", {63'd0, noise_ready}, 64'd0);
        @(posedge clk); #1;
        idle();
        drain();

        // Backpressure: only two frames fit while the output stalls
        out_ready = 1'b0;
        acc = 0;
        held = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            snr_code = 3'b010; in_valid = 1'b1; noise_valid = 1'b1;
            in_data = {32'h200 + 32'(acc), 32'h100 + 32'(acc)};
            noise_data = 64'h0;
            @(negedge clk);
            if (in_ready) begin
                mon_e.l = 32'h100 + 32'(acc); mon_e.r = 32'h200 + 32'(acc); mon_e.sat = 2'b00;
                exp_q.push_back(mon_e);
                acc++;
            end
            if (cyc == 2) held = out_data;
            if (cyc == 4) begin
                check("bp_in_ready", {63'd0, in_ready}, 64'd0);
                check("bp_out_valid", {63'd0, out_valid}, 64'd1);
                check("bp_out_stable", out_data, held);
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_head_frame", held, 64'h0000_0200_0000_0100);
        out_ready = 1'b1;
        send(3'b010, 32'h102, 32'h202, 32'h0, 32'h102, 32'h202, 2'b00);
        send(3'b010, 32'h103, 32'h203, 32'h0, 32'h103, 32'h203, 2'b00);
        idle();
        drain();

        // clr_stats coincident with a saturating handshake
        send(3'b101, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11);
        idle();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        check("clr_wait_out_valid", {63'd0, out_valid}, 64'd1);
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        @(negedge clk);
        check("clr_priority", {48'd0, sat_count}, 64'd0);
        @(posedge clk); #1;
        drain();

        // Reset with two frames in flight
        send(3'b101, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11);
        idle();
        drain();
        check("pre_rst_sat_count", {48'd0, sat_count}, 64'd2);
        out_ready = 1'b0;
        send(3'b010, 32'hAAAA0001, 32'hBBBB0001, 32'h0, 32'hAAAA0001, 32'hBBBB0001, 2'b00);
        send(3'b010, 32'hAAAA0002, 32'hBBBB0002, 32'h0, 32'hAAAA0002, 32'hBBBB0002, 2'b00);
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sat_count", {48'd0, sat_count}, 64'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;

        // Fill the counter to 0xFFFE, then overflow it and confirm it holds
        quiet = 1'b1;
        for (int i = 0; i < 32767; i++)
            send(3'b101, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11);
        idle();
        drain();
        quiet = 1'b0;
        check("fill_sat_count", {48'd0, sat_count}, 64'hFFFE);
        send(3'b101, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11);
        idle();
        drain();
        check("cnt_clamp", {48'd0, sat_count}, 64'hFFFF);
        send(3'b101, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11);
        idle();
        drain();
        check("cnt_hold", {48'd0, sat_count}, 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
